// File: rtl/orangecrab_reset_ctrl.sv
// Board-reset controller: debounced multi-source reset requests drive the active-low board reset pin and latch the cause.
// Optional watchdog is built only when ORANGECRAB_RESET_WDT_EN is defined.
module orangecrab_reset_ctrl #(
    parameter int                N_SRC       = 2,
    parameter int                HOLD_CYCLES = 1000,
    parameter logic [N_SRC-1:0]  SRC_MASK    = {N_SRC{1'b1}},
    parameter int                WDT_CYCLES  = 16777216
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic             wdt_kick,
    output logic             nreset_out,
    output logic             fired,
    output logic             pending,
    output logic [N_SRC:0]   cause
);

    localparam int             CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_MAX  = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, ARMING, FIRED} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt     [N_SRC];
    logic [CW-1:0]    cnt_nxt [N_SRC];
    logic [N_SRC-1:0] qual;
    logic [N_SRC-1:0] hit;
    logic [N_SRC:0]   cause_nxt;
    logic             any_cnt;
    logic             wdt_fire;

    assign qual = req & SRC_MASK;

`ifdef ORANGECRAB_RESET_WDT_EN
    localparam int             WW       = $clog2(WDT_CYCLES);
    localparam logic [WW-1:0]  WDT_LOAD = WW'(WDT_CYCLES - 1);

    logic          wdt_armed;
    logic [WW-1:0] wdt_cnt;

    // A kick on the expiry edge wins over the timeout.
    assign wdt_fire = wdt_armed && (wdt_cnt == '0) && !wdt_kick && (state != FIRED);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_armed <= 1'b0;
            wdt_cnt   <= WDT_LOAD;
        end else if (state != FIRED && !wdt_fire) begin
            if (wdt_kick) begin
                wdt_armed <= 1'b1;
                wdt_cnt   <= WDT_LOAD;
            end else if (wdt_armed && wdt_cnt != '0) begin
                wdt_cnt <= wdt_cnt - WW'(1);
            end
        end
    end
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_fire        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hit       = '0;
        any_cnt   = 1'b0;
        for (int i = 0; i < N_SRC; i++) cnt_nxt[i] = cnt[i];
        if (state != FIRED) begin
            for (int i = 0; i < N_SRC; i++) begin
                hit[i] = qual[i] && (cnt[i] == HOLD_LAST);
                if (!qual[i])                cnt_nxt[i] = '0;
                else if (cnt[i] != HOLD_MAX) cnt_nxt[i] = cnt[i] + CW'(1);
                if (cnt_nxt[i] != '0) any_cnt = 1'b1;
            end
            // Firing discards all partial counts so nothing re-arms until rst.
            if ((|hit) || wdt_fire) begin
                state_nxt = FIRED;
                for (int i = 0; i < N_SRC; i++) cnt_nxt[i] = '0;
            end else begin
                state_nxt = any_cnt ? ARMING : IDLE;
            end
        end
        cause_nxt = (state == FIRED) ? cause : {wdt_fire, hit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
            nreset_out <= 1'b1;
            fired      <= 1'b0;
            pending    <= 1'b0;
            cause      <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) cnt[i] <= cnt_nxt[i];
            nreset_out <= (state_nxt != FIRED);
            fired      <= (state_nxt == FIRED);
            pending    <= (state_nxt == ARMING);
            cause      <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_orangecrab_reset_ctrl.sv
// Self-checking bench: directed and random steps compared against a run-length reference model.
module tb_orangecrab_reset_ctrl;

    localparam int N = 2;
    localparam int H = 4;
    localparam int W = 8;
`ifdef ORANGECRAB_RESET_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         wdt_kick;

    logic         nreset_a, fired_a, pending_a;
    logic [N:0]   cause_a;
    logic         nreset_b, fired_b, pending_b;
    logic [N:0]   cause_b;

    int checks = 0;
    int errors = 0;

    // Reference model state: instance 0 has all channels enabled, instance 1 only channel 1.
    logic [N-1:0] mask   [2];
    int           run    [2][N];
    bit           mfired [2];
    logic [N:0]   mcause [2];
    bit           warmed [2];
    int           since  [2];

    always #5 clk = ~clk;

    orangecrab_reset_ctrl #(.N_SRC(N), .HOLD_CYCLES(H), .SRC_MASK(2'b11), .WDT_CYCLES(W)) u_all (
        .clk(clk), .rst(rst), .req(req), .wdt_kick(wdt_kick),
        .nreset_out(nreset_a), .fired(fired_a), .pending(pending_a), .cause(cause_a)
    );

    orangecrab_reset_ctrl #(.N_SRC(N), .HOLD_CYCLES(H), .SRC_MASK(2'b10), .WDT_CYCLES(W)) u_masked (
        .clk(clk), .rst(rst), .req(req), .wdt_kick(wdt_kick),
        .nreset_out(nreset_b), .fired(fired_b), .pending(pending_b), .cause(cause_b)
    );

    task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic k);
        logic [N:0] c;
        for (int u = 0; u < 2; u++) begin
            c = '0;
            if (r) begin
                mfired[u] = 1'b0;
                mcause[u] = '0;
                warmed[u] = 1'b0;
                since[u]  = 0;
                for (int i = 0; i < N; i++) run[u][i] = 0;
            end else if (!mfired[u]) begin
                for (int i = 0; i < N; i++) begin
                    if (rq[i] && mask[u][i]) run[u][i]++;
                    else                     run[u][i] = 0;
                    if (run[u][i] == H) c[i] = 1'b1;
                end
                if (WDT_ON) begin
                    if (k) begin
                        warmed[u] = 1'b1;
                        since[u]  = 0;
                    end else if (warmed[u]) begin
                        since[u]++;
                        if (since[u] == W) c[N] = 1'b1;
                    end
                end
                if (c != '0) begin
                    mfired[u] = 1'b1;
                    mcause[u] = c;
                    for (int i = 0; i < N; i++) run[u][i] = 0;
                end
            end
        end
    endtask

    function automatic bit modelPending(input int u);
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (run[u][i] > 0) p = 1'b1;
        return p && !mfired[u];
    endfunction

    task automatic checkOutput(input string tag);
        checkOne({tag, ".a.nreset"},  {7'b0, nreset_a},  {7'b0, !mfired[0]});
        checkOne({tag, ".a.fired"},   {7'b0, fired_a},   {7'b0, mfired[0]});
        checkOne({tag, ".a.pending"}, {7'b0, pending_a}, {7'b0, modelPending(0)});
        checkOne({tag, ".a.cause"},   {5'b0, cause_a},   {5'b0, mcause[0]});
        checkOne({tag, ".b.nreset"},  {7'b0, nreset_b},  {7'b0, !mfired[1]});
        checkOne({tag, ".b.fired"},   {7'b0, fired_b},   {7'b0, mfired[1]});
        checkOne({tag, ".b.pending"}, {7'b0, pending_b}, {7'b0, modelPending(1)});
        checkOne({tag, ".b.cause"},   {5'b0, cause_b},   {5'b0, mcause[1]});
    endtask

    task automatic applyStimulus(input string tag, input logic r, input logic [N-1:0] rq, input logic k);
        rst      = r;
        req      = rq;
        wdt_kick = k;
        @(posedge clk);
        modelStep(r, rq, k);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [N-1:0] rr;
        mask[0] = 2'b11;
        mask[1] = 2'b10;
        rst = 1'b1; req = '0; wdt_kick = 1'b0;

        // Reset state
        applyStimulus("reset0", 1'b1, 2'b00, 1'b0);
        applyStimulus("reset1", 1'b1, 2'b00, 1'b0);
        checkOne("reset.nreset", {7'b0, nreset_a}, 8'h01);

        // Single channel held for H edges fires on edge H
        for (int e = 1; e <= H; e++) applyStimulus("hold0", 1'b0, 2'b01, 1'b0);
        checkOne("hold0.fired", {7'b0, fired_a}, 8'h01);
        checkOne("hold0.cause", {5'b0, cause_a}, 8'h01);
        checkOne("hold0.masked_fired", {7'b0, fired_b}, 8'h00);

        // Inputs ignored once fired
        for (int e = 0; e < 20; e++) applyStimulus("frozen", 1'b0, N'($urandom), 1'($urandom));
        checkOne("frozen.cause", {5'b0, cause_a}, 8'h01);
        applyStimulus("rst1", 1'b1, 2'b11, 1'b1);
        checkOne("rst1.fired", {7'b0, fired_a}, 8'h00);
        checkOne("rst1.cause", {5'b0, cause_a}, 8'h00);

        // Glitch restarts the count
        for (int e = 0; e < 3; e++) applyStimulus("glitchA", 1'b0, 2'b01, 1'b0);
        applyStimulus("glitchLow", 1'b0, 2'b00, 1'b0);
        checkOne("glitch.pending", {7'b0, pending_a}, 8'h00);
        for (int e = 0; e < 3; e++) applyStimulus("glitchB", 1'b0, 2'b01, 1'b0);
        applyStimulus("glitchEnd", 1'b0, 2'b00, 1'b0);
        checkOne("glitch.nreset", {7'b0, nreset_a}, 8'h01);

        // Simultaneous requests set multiple cause bits
        for (int e = 0; e < H; e++) applyStimulus("both", 1'b0, 2'b11, 1'b0);
        checkOne("both.cause", {5'b0, cause_a}, 8'h03);
        checkOne("both.masked_cause", {5'b0, cause_b}, 8'h02);
        applyStimulus("rst2", 1'b1, 2'b00, 1'b0);

        // Masked channel never fires
        for (int e = 0; e < 3 * H; e++) applyStimulus("mask", 1'b0, 2'b01, 1'b0);
        checkOne("mask.fired", {7'b0, fired_b}, 8'h00);
        applyStimulus("rst3", 1'b1, 2'b00, 1'b0);

        // rst mid-count clears the counter
        for (int e = 0; e < H - 1; e++) applyStimulus("midA", 1'b0, 2'b01, 1'b0);
        applyStimulus("midRst", 1'b1, 2'b01, 1'b0);
        for (int e = 0; e < H - 1; e++) applyStimulus("midB", 1'b0, 2'b01, 1'b0);
        checkOne("mid.notyet", {7'b0, fired_a}, 8'h00);
        applyStimulus("midFire", 1'b0, 2'b01, 1'b0);
        checkOne("mid.fired", {7'b0, fired_a}, 8'h01);
        applyStimulus("rst4", 1'b1, 2'b00, 1'b0);

        // Watchdog: disarmed until first kick, expiry, kick on expiry edge
        for (int e = 0; e < 100; e++) applyStimulus("wdtIdle", 1'b0, 2'b00, 1'b0);
        checkOne("wdtIdle.fired", {7'b0, fired_a}, 8'h00);
        applyStimulus("wdtKick", 1'b0, 2'b00, 1'b1);
        for (int e = 0; e < W; e++) applyStimulus("wdtRun", 1'b0, 2'b00, 1'b0);
        checkOne("wdtExpire.cause", {5'b0, cause_a}, WDT_ON ? 8'h04 : 8'h00);
        applyStimulus("rst5", 1'b1, 2'b00, 1'b0);
        applyStimulus("wdtKick2", 1'b0, 2'b00, 1'b1);
        for (int e = 0; e < W - 1; e++) applyStimulus("wdtRun2", 1'b0, 2'b00, 1'b0);
        applyStimulus("wdtSave", 1'b0, 2'b00, 1'b1);
        checkOne("wdtSave.fired", {7'b0, fired_a}, 8'h00);
        for (int e = 0; e < W; e++) applyStimulus("wdtRun3", 1'b0, 2'b00, 1'b0);
        applyStimulus("rst6", 1'b1, 2'b00, 1'b0);

        // Random phase: sticky requests, occasional kicks and resets
        rr = '0;
        for (int e = 0; e < 500; e++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) rr[i] = ~rr[i];
            applyStimulus("rand", ($urandom_range(40) == 0), rr, ($urandom_range(9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/orangecrab_reset_ctrl.md
# orangecrab_reset_ctrl

Parametrised board-reset controller for the OrangeCrab: it gathers several reset-request sources, requires each one to stay asserted for a programmable number of consecutive cycles, and then drives the board's active-low reset pin low and keeps it there. It records which source caused the reset. It can optionally include a watchdog that forces a reset when software stops kicking it. It sits at the top level, between request sources (button synchroniser, USB DFU command, soft-reset register) and the FPGA pin that resets the board.

## Interface
- N_SRC, 2, number of request channels (1..8)
- HOLD_CYCLES, 1000, consecutive high cycles a request needs before it fires (>= 1)
- SRC_MASK, {N_SRC{1'b1}}, per-channel enable; a masked channel never fires
- WDT_CYCLES, 16777216, watchdog timeout in cycles (>= 2; used only with the watchdog macro)

- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req  in  N_SRC  reset request per channel; already synchronised to clk
- wdt_kick  in  1  watchdog kick pulse; ignored when the watchdog is compiled out
- nreset_out  out  1  active-low board reset; 1 = run, 0 = reset the board
- fired  out  1  reset has been triggered; latched
- pending  out  1  at least one hold counter is non-zero
- cause  out  N_SRC+1  bits [N_SRC-1:0] are the firing channels; bit N_SRC is the watchdog

## Operation
- All outputs are registered.
- Reset values:
  - nreset_out = 1
  - fired = 0
  - pending = 0
  - cause = 0
  - every hold counter = 0
  - watchdog disarmed, with its counter at WDT_CYCLES-1
- Hold counters:
  - One counter per channel, $clog2(HOLD_CYCLES+1) bits wide. It saturates and never wraps.
  - When req[i] & SRC_MASK[i] is sampled high, the counter increments.
  - When it is sampled low, the counter clears to 0. A glitch therefore restarts the count.
- States:
  - IDLE: all counters are 0.
  - ARMING: some counter is non-zero; pending = 1.
  - FIRED: nreset_out = 0 and fired = 1.
- Transitions:
  - IDLE -> ARMING on the first qualified request.
  - ARMING -> IDLE when all counters return to 0.
  - ARMING or IDLE -> FIRED on the edge where any counter would reach HOLD_CYCLES, or when the watchdog expires.
  - FIRED is left only by rst.
- On entry to FIRED:
  - cause latches every channel whose counter reaches HOLD_CYCLES on that same edge, plus the watchdog bit if it expires on that edge. Simultaneous triggers therefore set multiple bits.
  - Counters clear, pending = 0, and from then on req and wdt_kick are ignored.
- Once FIRED, cause is held until rst.
- rst asserted in any state, including mid-count or FIRED, returns everything to its reset values on the next edge.

## Timing
- A request sampled high on edges 1..H, where H = HOLD_CYCLES, sets nreset_out = 0 and fired = 1 immediately after edge H.
  - With HOLD_CYCLES = 1, this happens after the first edge that samples the request high.
- pending rises after the first edge that samples a qualified request high. It falls after the edge that samples all requests low.
- A request that drops at edge H-1 or earlier never fires.
- Watchdog: after expiry, nreset_out drops after that same edge.
- rst deasserted: nreset_out = 1 is visible after the edge that samples rst high. It stays 1 until the next trigger.

## Configuration
- Macro: ORANGECRAB_RESET_WDT_EN.
- Defined:
  - The watchdog is disarmed after rst. It arms on the first wdt_kick.
  - Each kick reloads the counter to WDT_CYCLES-1.
  - While armed, the counter decrements every cycle. The edge on which it is sampled at 0 with no kick fires the reset with cause[N_SRC] = 1.
  - A kick on that same edge wins and no reset occurs.
  - Expiry occurs WDT_CYCLES edges after the last kick.
- Undefined:
  - No watchdog logic is built.
  - wdt_kick is ignored and cause[N_SRC] is tied to 0.

## Test plan
- HOLD_CYCLES=4, req[0] high for 4 edges -> nreset_out=0, fired=1, cause=3'b001 after edge 4; pending=1 from edge 1 until that edge.
- HOLD_CYCLES=4, req[0] high 3 edges, low 1, high 3 -> no fire, pending returns to 0 in between, nreset_out stays 1.
- req[0] and req[1] rise together, HOLD_CYCLES=4 -> fires after edge 4 with cause=3'b011; SRC_MASK=2'b10 with req[0] only -> never fires.
- After FIRED, toggle req and wdt_kick for 20 cycles -> outputs unchanged; rst for 1 cycle -> nreset_out=1, fired=0, cause=0 after the edge.
- WDT_EN defined, WDT_CYCLES=8: no kick after rst for 100 cycles -> no fire; kick once then idle -> fires 8 edges after the kick with cause=3'b100; kick on the expiry edge -> no fire.
- rst asserted when a counter is at 3 of 4 -> counter cleared, and req held high afterwards needs 4 new edges to fire.
